// File: rtl/mips_fetch_pkg.sv
// Shared types and defaults for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  RESET_PC_DEF  = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pcplus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched instructions; flush overrides push and pop.
module fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_entry_t           data_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   do_push;
    logic                   do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer/count next state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        do_push  = push_i & ~flush_i;
        do_pop   = pop_i & ~flush_i & ~empty_o;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues one IMEM read per cycle while there is
// room, and queues returned instructions with their PC+4 for decode.
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC    = RESET_PC_DEF,
    parameter int unsigned        QUEUE_DEPTH = 2,
    parameter logic [INSTR_W-1:0] NOP_INSTR   = NOP_INSTR_DEF
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         Redirect,
    input  logic [ADDR_W-1:0]            RedirectPC,
    output logic                         IMemReq,
    output logic [ADDR_W-1:0]            IMemAddr,
    input  logic [INSTR_W-1:0]           IMemRdata,
    input  logic                         StallD,
    output logic                         ValidD,
    output logic [INSTR_W-1:0]           InstrD,
    output logic [ADDR_W-1:0]            PCPlus4D,
    output logic [$clog2(QUEUE_DEPTH):0] Occupancy
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned LVL_W = CNT_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] pcplus4_q, pcplus4_d;

    fetch_entry_t      q_head;
    fetch_entry_t      q_data;
    logic [CNT_W-1:0]  q_count;
    logic              q_full;
    logic              q_empty;
    logic              pop_c;
    logic              push_c;
    logic              issue_c;
    logic [LVL_W-1:0]  level_c;

    // Entries that will be queued or owed once this cycle settles; issue only if one more fits.
    always_comb begin
        ValidD  = RST & ~q_empty;
        pop_c   = ValidD & ~StallD;
        push_c  = RST & inflight_q & ~Redirect;
        level_c = LVL_W'(q_count) + LVL_W'(inflight_q) - LVL_W'(pop_c);
        issue_c = RST & ~Redirect & (level_c < LVL_W'(QUEUE_DEPTH));
        q_data  = '{instr: IMemRdata, pcplus4: pcplus4_q};
    end

    always_comb begin
        pc_d       = pc_q;
        inflight_d = 1'b0;
        pcplus4_d  = pcplus4_q;
        if (Redirect) begin
            pc_d = RedirectPC;
        end else if (issue_c) begin
            pc_d       = pc_q + ADDR_W'(4);
            inflight_d = 1'b1;
            pcplus4_d  = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            pcplus4_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            pcplus4_q  <= pcplus4_d;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (CLK),
        .rst_n   (RST),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .flush_i (Redirect),
        .data_i  (q_data),
        .head_o  (q_head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign IMemReq   = issue_c;
    assign IMemAddr  = pc_q;
    assign InstrD    = ValidD ? q_head.instr : NOP_INSTR;
    assign PCPlus4D  = ValidD ? q_head.pcplus4 : '0;
    assign Occupancy = q_count;

    // The issue rule guarantees a slot for every returning response.
    always_ff @(posedge CLK) begin
        if (RST && push_c) begin
            assert (!q_full) else $error("fetch_unit: push into full fetch queue");
        end
    end

endmodule
